rect_store: RTL and testbench

Double-buffered rectangle table that sits directly downstream of `rect_copy_controller`. It consumes the controller's 16-bit word stream and packs every five consecutive words into one rectangle record (x, y, width, height, color) in a back bank. On a frame-swap pulse, it exposes the completed bank to the GPU rasterizer through a registered, indexed read port.

---
 rtl/rect_store.sv | 149 ++++++++++++++
 tb/tb_rect_store.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_store.sv
// Double-buffered rectangle table: packs 5-word records into the back bank, swaps banks on vsync.
// Read latency 1 cycle; no backpressure, one din word per cycle; words outside a load set sticky overflow.
module rect_store #(
    parameter int RECT_COUNT     = 64,
    parameter int INDEX_WIDTH    = 6,
    parameter int WORDS_PER_RECT = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   copy_start,
    input  logic                   din_valid,
    input  logic [15:0]            din,
    input  logic                   swap,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic [15:0]            rd_x,
    output logic [15:0]            rd_y,
    output logic [15:0]            rd_w,
    output logic [15:0]            rd_h,
    output logic [15:0]            rd_color,
    output logic                   load_done,
    output logic                   frame_miss,
    output logic                   overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
        logic [15:0] color;
    } rect_t;

    state_e                 state_q, state_d;
    logic                   front_q, front_d;
    logic [2:0]             word_cnt_q, word_cnt_d;
    logic [INDEX_WIDTH:0]   rect_cnt_q, rect_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   miss_q, miss_d;
    logic                   wr_en;
    logic                   swap_ok;
    logic                   last_word;
    logic [INDEX_WIDTH:0]   rect_inc;
    logic [INDEX_WIDTH:0]   wr_addr;
    logic [INDEX_WIDTH:0]   rd_addr;
    rect_t                  rd_q;
    rect_t                  mem_q [2*RECT_COUNT];

    assign rect_inc  = rect_cnt_q + (INDEX_WIDTH+1)'(1);
    assign last_word = (word_cnt_q == 3'(WORDS_PER_RECT-1)) &&
                       (rect_inc == (INDEX_WIDTH+1)'(RECT_COUNT));
    assign swap_ok   = swap && (state_q == S_DONE);
    assign wr_addr   = {~front_q, rect_cnt_q[INDEX_WIDTH-1:0]};
    assign rd_addr   = {front_q, rd_index};

    always_comb begin
        state_d    = state_q;
        front_d    = front_q;
        word_cnt_d = word_cnt_q;
        rect_cnt_d = rect_cnt_q;
        ovf_d      = ovf_q;
        miss_d     = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (din_valid && !copy_start) begin
                    wr_en = 1'b1;
                    if (word_cnt_q == 3'(WORDS_PER_RECT-1)) begin
                        word_cnt_d = '0;
                        rect_cnt_d = rect_inc;
                        if (last_word) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                if (din_valid) begin
                    ovf_d = 1'b1;
                end
            end
        endcase

        // Swap resolves on the pre-edge state; a missed swap leaves any load running.
        if (swap) begin
            if (swap_ok) begin
                front_d = ~front_q;
                state_d = S_IDLE;
            end else begin
                miss_d = 1'b1;
            end
        end

        // copy_start wins last so it targets the post-swap back bank.
        if (copy_start) begin
            state_d    = S_LOAD;
            word_cnt_d = '0;
            rect_cnt_d = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            front_q    <= 1'b0;
            word_cnt_q <= '0;
            rect_cnt_q <= '0;
            ovf_q      <= 1'b0;
            miss_q     <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_d;
            word_cnt_q <= word_cnt_d;
            rect_cnt_q <= rect_cnt_d;
            ovf_q      <= ovf_d;
            miss_q     <= miss_d;
            rd_q       <= mem_q[rd_addr];
        end
    end

    // Bank storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (word_cnt_q)
                3'd0:    mem_q[wr_addr].x     <= din;
                3'd1:    mem_q[wr_addr].y     <= din;
                3'd2:    mem_q[wr_addr].w     <= din;
                3'd3:    mem_q[wr_addr].h     <= din;
                default: mem_q[wr_addr].color <= din;
            endcase
        end
    end

    assign rd_x       = rd_q.x;
    assign rd_y       = rd_q.y;
    assign rd_w       = rd_q.w;
    assign rd_h       = rd_q.h;
    assign rd_color   = rd_q.color;
    assign load_done  = (state_q == S_DONE);
    assign frame_miss = miss_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_rect_store.sv
// Bench for rect_store: directed vector table, hand sequences and random traffic against a frame-level model.
module tb_rect_store;
    localparam int RC = 64;
    localparam int IW = 6;
    localparam int NW = RC * 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          copy_start;
    logic          din_valid;
    logic [15:0]   din;
    logic          swap;
    logic [IW-1:0] rd_index;
    logic [15:0]   rd_x, rd_y, rd_w, rd_h, rd_color;
    logic          load_done, frame_miss, overflow;

    rect_store #(.RECT_COUNT(RC), .INDEX_WIDTH(IW), .WORDS_PER_RECT(5)) dut (
        .clk(clk), .reset(reset), .copy_start(copy_start), .din_valid(din_valid),
        .din(din), .swap(swap), .rd_index(rd_index),
        .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w), .rd_h(rd_h), .rd_color(rd_color),
        .load_done(load_done), .frame_miss(frame_miss), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model: the loading frame is a queue of words, the front frame a flat array.
    logic [15:0] m_frame[$];
    logic [15:0] m_front[NW];
    bit          m_front_vld, m_loading, m_done, m_ovf, m_miss;
    logic [15:0] e_rd[5];
    bit          e_rd_vld;

    typedef struct {
        bit          cs;
        bit          dv;
        bit          sw;
        logic [15:0] d;
        bit          e_done;
        bit          e_miss;
        bit          e_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_front_vld = 0;
        m_loading   = 0;
        m_done      = 0;
        m_ovf       = 0;
        m_miss      = 0;
        e_rd_vld    = 0;
    endtask

    task automatic model_edge(input bit cs, input bit dv, input logic [15:0] d,
                              input bit sw, input logic [IW-1:0] idx);
        bit pre_done;
        e_rd_vld = m_front_vld;
        for (int k = 0; k < 5; k++) e_rd[k] = m_front[int'(idx)*5 + k];
        pre_done = m_done;
        m_miss   = sw && !pre_done;
        if (sw && pre_done) begin
            for (int i = 0; i < NW; i++) m_front[i] = m_frame[i];
            m_front_vld = 1;
            m_done      = 0;
        end
        if (cs) begin
            m_frame.delete();
            m_loading = 1;
            m_done    = 0;
            m_ovf     = 0;
        end else if (dv) begin
            if (m_loading) begin
                m_frame.push_back(d);
                if (m_frame.size() == NW) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("load_done", load_done, m_done);
        chk("frame_miss", frame_miss, m_miss);
        chk("overflow", overflow, m_ovf);
        if (e_rd_vld) begin
            chk("rd_x", rd_x, e_rd[0]);
            chk("rd_y", rd_y, e_rd[1]);
            chk("rd_w", rd_w, e_rd[2]);
            chk("rd_h", rd_h, e_rd[3]);
            chk("rd_color", rd_color, e_rd[4]);
        end
    endtask

    task automatic step(input bit cs, input bit dv, input logic [15:0] d,
                        input bit sw, input logic [IW-1:0] idx);
        copy_start = cs;
        din_valid  = dv;
        din        = d;
        swap       = sw;
        rd_index   = idx;
        @(posedge clk);
        model_edge(cs, dv, d, sw, idx);
        #1;
        check_outputs();
        copy_start = 0;
        din_valid  = 0;
        swap       = 0;
    endtask

    task automatic load_words(input int n, input int base);
        for (int i = 0; i < n; i++)
            step(0, 1, 16'(base + i), 0, IW'($urandom_range(0, RC-1)));
    endtask

    task automatic do_reset();
        reset      = 1;
        copy_start = 0;
        din_valid  = 0;
        din        = '0;
        swap       = 0;
        rd_index   = '0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_load_done", load_done, 0);
        chk("rst_frame_miss", frame_miss, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_x", rd_x, 0);
        chk("rst_rd_y", rd_y, 0);
        chk("rst_rd_w", rd_w, 0);
        chk("rst_rd_h", rd_h, 0);
        chk("rst_rd_color", rd_color, 0);
        reset = 0;
    endtask

    vec_t tbl[8];

    initial begin
        reset = 1; copy_start = 0; din_valid = 0; din = '0; swap = 0; rd_index = '0;
        //            cs dv sw d        done miss ovf
        tbl[0] = '{0, 1, 0, 16'h1111, 0, 0, 1};
        tbl[1] = '{0, 0, 0, 16'h0000, 0, 0, 1};
        tbl[2] = '{0, 0, 1, 16'h0000, 0, 1, 1};
        tbl[3] = '{0, 0, 0, 16'h0000, 0, 0, 1};
        tbl[4] = '{1, 0, 0, 16'h0000, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 16'h2222, 0, 0, 0};
        tbl[6] = '{0, 0, 1, 16'h0000, 0, 1, 0};
        tbl[7] = '{1, 0, 0, 16'h0000, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].cs, tbl[i].dv, tbl[i].d, tbl[i].sw, '0);
            chk($sformatf("vec%0d_done", i), load_done, tbl[i].e_done);
            chk($sformatf("vec%0d_miss", i), frame_miss, tbl[i].e_miss);
            chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].e_ovf);
        end

        // Full load of word index values, then swap and read record 7.
        load_words(NW, 0);
        chk("full_done", load_done, 1);
        step(0, 0, 0, 1, 0);
        chk("full_done_after_swap", load_done, 0);
        step(0, 0, 0, 0, 7);
        chk("full_rd_x", rd_x, 35);
        chk("full_rd_y", rd_y, 36);
        chk("full_rd_w", rd_w, 37);
        chk("full_rd_h", rd_h, 38);
        chk("full_rd_color", rd_color, 39);

        // Early swap after 100 words.
        step(1, 0, 0, 0, 7);
        load_words(100, 16'h1000);
        step(0, 0, 0, 1, 7);
        chk("early_miss", frame_miss, 1);
        chk("early_rd_x", rd_x, 35);
        step(0, 0, 0, 0, 7);
        chk("early_miss_clear", frame_miss, 0);
        load_words(NW - 100, 16'h1000 + 100);
        chk("early_done", load_done, 1);

        // Stray word in DONE, then swap and copy_start together.
        step(0, 1, 16'hDEAD, 0, 0);
        chk("stray_done_ovf", overflow, 1);
        step(0, 0, 0, 0, 0);
        chk("stray_ovf_sticky", overflow, 1);
        step(1, 0, 0, 1, 0);
        chk("swapcs_done", load_done, 0);
        chk("swapcs_ovf", overflow, 0);
        step(0, 0, 0, 0, 0);
        chk("swapcs_rd_x", rd_x, 16'h1000);
        load_words(NW - 1, 16'h2000);
        step(0, 1, 16'h2000 + 16'(NW - 1), 1, 1);
        chk("lastswap_miss", frame_miss, 1);
        chk("lastswap_done", load_done, 1);
        chk("lastswap_rd_x", rd_x, 16'h1005);

        // Restart mid-load.
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 16'h5555, 0, 0);
        step(1, 0, 0, 0, 0);
        load_words(NW, 16'hA000);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("restart_rd_x", rd_x, 16'hA000);
        step(0, 0, 0, 0, 2);
        chk("restart_rd_color", rd_color, 16'hA00E);

        // Reset mid-load at word 150.
        step(1, 0, 0, 0, 0);
        load_words(150, 16'h7000);
        do_reset();
        step(0, 1, 16'hBEEF, 0, 0);
        chk("post_rst_ovf", overflow, 1);
        step(1, 0, 0, 0, 0);
        load_words(NW, 16'h3000);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 63);
        chk("post_rst_rd_color", rd_color, 16'h313F);
        chk("post_rst_rd_x", rd_x, 16'h3000 + 16'(63*5));

        // Random traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
                 16'($urandom), $urandom_range(0, 149) == 0,
                 IW'($urandom_range(0, RC-1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
